// File: rtl/conv_s2_sched_pkg.sv
// Shared types and helpers for the stride-2 3x3 window scheduler.
package conv_s2_sched_pkg;

    localparam int KSIZE = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/conv_s2_delay.sv
// Fixed-latency valid/payload delay line, advancing every cycle.
module conv_s2_delay #(
    parameter int LAT = 3,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         v_in,
    input  logic [W-1:0] d_in,
    output logic         v_out,
    output logic [W-1:0] d_out
);

    logic [LAT-1:0] vld;
    logic [W-1:0]   dat [LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) dat[i] <= '0;
        end else begin
            vld[0] <= v_in;
            dat[0] <= d_in;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign v_out = vld[LAT-1];
    assign d_out = dat[LAT-1];

endmodule

// File: rtl/conv_s2_sched.sv
// Stride-2 3x3 convolution scheduler: pixel counting, window
// timing and kernel coefficient storage.
module conv_s2_sched
    import conv_s2_sched_pkg::*;
#(
    parameter int D          = 220,
    parameter int DATA_WIDTH = 32,
    parameter int LAT        = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        valid_in,
    output logic                        in_ready,
    output logic                        pxl_en,
    input  logic                        k_wr,
    input  logic [3:0]                  k_addr,
    input  logic [DATA_WIDTH-1:0]       k_data,
    output logic [KSIZE*DATA_WIDTH-1:0] kernel_flat,
    output logic                        win_valid,
    output logic [clog2(D)-1:0]         out_row,
    output logic [clog2(D)-1:0]         out_col,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        k_err
);

    localparam int AW = clog2(D);
    localparam int CW = clog2(LAT + 1);
    localparam logic [AW-1:0] LASTC = AW'(D - 1);
    localparam logic [CW-1:0] DLAST = CW'(LAT - 1);

    state_t state_q, state_d;

    logic [AW-1:0]         row, col;
    logic [CW-1:0]         dcnt;
    logic [DATA_WIDTH-1:0] coef [KSIZE];
    logic                  last_px;
    logic                  win_hit;
    logic                  k_ok;
    logic [2*AW-1:0]       win_pl;
    logic [2*AW-1:0]       dly_pl;
    logic                  dly_v;

    assign in_ready = (state_q == S_RUN);
    assign pxl_en   = valid_in & in_ready;
    assign last_px  = pxl_en && (row == LASTC) && (col == LASTC);

    // Even and nonzero means the 3x3 stride-2 window just closed.
    assign win_hit = pxl_en && (row != '0) && !row[0]
                            && (col != '0) && !col[0];
    assign win_pl  = win_hit ? {(row >> 1) - AW'(1), (col >> 1) - AW'(1)}
                             : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_px) state_d = S_DRAIN;
            S_DRAIN: if (dcnt == DLAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row     <= '0;
            col     <= '0;
            dcnt    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                row <= '0;
                col <= '0;
            end else if (pxl_en) begin
                if (col == LASTC) begin
                    col <= '0;
                    row <= row + AW'(1);
                end else begin
                    col <= col + AW'(1);
                end
            end
            if (state_q == S_DRAIN) dcnt <= dcnt + CW'(1);
            else                    dcnt <= '0;
        end
    end

    assign k_ok = k_wr && (state_q == S_IDLE) && (k_addr <= 4'd8);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_err <= 1'b0;
            for (int i = 0; i < KSIZE; i++) coef[i] <= '0;
        end else begin
            k_err <= k_wr && !k_ok;
            if (k_ok) coef[k_addr] <= k_data;
        end
    end

    for (genvar g = 0; g < KSIZE; g++) begin : g_kflat
        assign kernel_flat[g*DATA_WIDTH +: DATA_WIDTH] = coef[g];
    end

    conv_s2_delay #(
        .LAT (LAT),
        .W   (2 * AW)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .v_in  (win_hit),
        .d_in  (win_pl),
        .v_out (dly_v),
        .d_out (dly_pl)
    );

    assign win_valid  = dly_v;
    assign out_row    = dly_v ? dly_pl[2*AW-1:AW] : '0;
    assign out_col    = dly_v ? dly_pl[AW-1:0]    : '0;
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_s2_sched.sv
// Self-checking bench for conv_s2_sched (D=6 model-checked, D=220 full frame).
module tb_conv_s2_sched;

    localparam int D   = 6;
    localparam int DB  = 220;
    localparam int LAT = 3;
    localparam int DW  = 32;
    localparam int DD  = D * D;
    localparam int NWIN = ((D - 3) / 2 + 1) * ((D - 3) / 2 + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            start, valid_in, k_wr;
    logic [3:0]      k_addr;
    logic [DW-1:0]   k_data;
    logic            in_ready, pxl_en, win_valid, busy, frame_done, k_err;
    logic [9*DW-1:0] kernel_flat;
    logic [2:0]      out_row, out_col;

    logic            start_b, valid_b, k_wr_b;
    logic [3:0]      k_addr_b;
    logic [DW-1:0]   k_data_b;
    logic            in_ready_b, pxl_en_b, win_b, busy_b, done_b, kerr_b;
    logic [9*DW-1:0] kernel_flat_b;
    logic [7:0]      row_b, col_b;

    conv_s2_sched #(.D(D), .DATA_WIDTH(DW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .valid_in(valid_in),
        .in_ready(in_ready), .pxl_en(pxl_en), .k_wr(k_wr),
        .k_addr(k_addr), .k_data(k_data), .kernel_flat(kernel_flat),
        .win_valid(win_valid), .out_row(out_row), .out_col(out_col),
        .busy(busy), .frame_done(frame_done), .k_err(k_err)
    );

    conv_s2_sched #(.D(DB), .DATA_WIDTH(DW), .LAT(LAT)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .valid_in(valid_b),
        .in_ready(in_ready_b), .pxl_en(pxl_en_b), .k_wr(k_wr_b),
        .k_addr(k_addr_b), .k_data(k_data_b), .kernel_flat(kernel_flat_b),
        .win_valid(win_b), .out_row(row_b), .out_col(col_b),
        .busy(busy_b), .frame_done(done_b), .k_err(kerr_b)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: cycle index, frame progress, expected windows by cycle.
    int          t = 0;
    bit          frame_active = 0;
    int          n_acc = 0;
    int          last_t = 0;
    bit          kerr_exp = 0;
    int          exp_win [int];
    logic [DW-1:0] km [9];
    int          win_seen = 0;
    int          done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_kernel();
        logic [9*DW-1:0] kexp;
        for (int i = 0; i < 9; i++) kexp[i*DW +: DW] = km[i];
        checks++;
        assert (kernel_flat === kexp) else begin
            failures++;
            $error("FAIL kernel_flat observed=%0h expected=%0h",
                   kernel_flat, kexp);
        end
    endtask

    task automatic check_out();
        int  e;
        bit  run_now, drain, done;
        e = exp_win.exists(t) ? exp_win[t] : -1;
        if (e >= 0) exp_win.delete(t);
        run_now = frame_active && n_acc < DD;
        drain = frame_active && n_acc == DD && t <= last_t + LAT;
        done = frame_active && n_acc == DD && t == last_t + LAT + 1;
        chk("win_valid", 32'(win_valid), 32'(e >= 0));
        chk("out_row", 32'(out_row), e >= 0 ? 32'(e / 256) : 32'd0);
        chk("out_col", 32'(out_col), e >= 0 ? 32'(e % 256) : 32'd0);
        chk("busy", 32'(busy), 32'(run_now || drain));
        chk("frame_done", 32'(frame_done), 32'(done));
        chk("k_err", 32'(k_err), 32'(kerr_exp));
        chk_kernel();
        if (win_valid === 1'b1) win_seen++;
        if (frame_done === 1'b1) done_seen++;
    endtask

    task automatic cyc(input bit v, input bit s, input bit kw = 0,
                       input logic [3:0] ka = 4'd0,
                       input logic [DW-1:0] kd = '0);
        bit idle, run, acc, ok;
        int r, c;
        valid_in = v; start = s; k_wr = kw; k_addr = ka; k_data = kd;
        #1;
        idle = !frame_active || (n_acc == DD && t > last_t + LAT + 1);
        run = frame_active && n_acc < DD;
        acc = v && run;
        chk("in_ready", 32'(in_ready), 32'(run));
        chk("pxl_en", 32'(pxl_en), 32'(acc));
        if (acc) begin
            r = n_acc / D;
            c = n_acc % D;
            if (r >= 2 && c >= 2 && r % 2 == 0 && c % 2 == 0)
                exp_win[t + LAT] = ((r - 2) / 2) * 256 + (c - 2) / 2;
            n_acc++;
            if (n_acc == DD) last_t = t;
        end
        ok = kw && idle && ka <= 4'd8;
        if (ok) km[ka] = kd;
        kerr_exp = kw && !ok;
        if (s && idle) begin
            frame_active = 1;
            n_acc = 0;
        end
        @(posedge clk);
        #1;
        t++;
        valid_in = 0; start = 0; k_wr = 0;
        check_out();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0);
    endtask

    task automatic model_reset();
        frame_active = 0;
        n_acc = 0;
        kerr_exp = 0;
        exp_win.delete();
        for (int i = 0; i < 9; i++) km[i] = '0;
    endtask

    int w0, d0, nb, nd, lr, lc;
    bit prev_busy;

    initial begin
        reset = 0;
        start = 0; valid_in = 0; k_wr = 0; k_addr = 0; k_data = 0;
        start_b = 0; valid_b = 0; k_wr_b = 0; k_addr_b = 0; k_data_b = 0;
        model_reset();
        #2;
        check_out();
        #1 reset = 1;
        idle_cycles(3);

        // Kernel load 1..9, then an out-of-range address.
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 4'(i), DW'(i + 1));
        cyc(0, 0, 1, 4'd9, 32'd77);
        idle_cycles(1);

        // Back-to-back frame with a rejected write during RUN.
        w0 = win_seen; d0 = done_seen;
        cyc(0, 1);
        for (int i = 0; i < DD; i++) begin
            if (i == 5) cyc(1, 0, 1, 4'd3, 32'd99);
            else        cyc(1, 0);
        end
        idle_cycles(LAT + 3);
        chk("frameA_windows", 32'(win_seen - w0), 32'(NWIN));
        chk("frameA_done", 32'(done_seen - d0), 32'd1);

        // valid_in toggling every cycle.
        w0 = win_seen; d0 = done_seen;
        cyc(0, 1);
        for (int i = 0; i < 4 * DD && n_acc < DD; i++) cyc(i % 2 == 0, 0);
        idle_cycles(LAT + 3);
        chk("frameB_windows", 32'(win_seen - w0), 32'(NWIN));
        chk("frameB_done", 32'(done_seen - d0), 32'd1);

        // start pulses in RUN and DRAIN are ignored.
        w0 = win_seen; d0 = done_seen;
        cyc(0, 1);
        for (int i = 0; i < DD; i++) cyc(1, i == 10);
        cyc(0, 1);
        cyc(0, 1);
        idle_cycles(LAT + 3);
        chk("frameC_windows", 32'(win_seen - w0), 32'(NWIN));
        chk("frameC_done", 32'(done_seen - d0), 32'd1);

        // Write + start together, random gaps and random rejected writes.
        w0 = win_seen; d0 = done_seen;
        cyc(0, 1, 1, 4'd4, 32'h5555_aaaa);
        for (int i = 0; i < 8 * DD && n_acc < DD; i++)
            cyc($urandom_range(0, 1) == 1, 0, $urandom_range(0, 7) == 0,
                4'($urandom_range(0, 9)), $urandom);
        idle_cycles(LAT + 3);
        chk("frameR_windows", 32'(win_seen - w0), 32'(NWIN));
        chk("frameR_done", 32'(done_seen - d0), 32'd1);
        for (int i = 0; i < 6; i++)
            cyc(0, 0, 1, 4'($urandom_range(0, 15)), $urandom);
        idle_cycles(1);

        // Asynchronous reset mid-frame, after pixel 20.
        cyc(0, 1);
        for (int i = 0; i <= 20; i++) cyc(1, 0);
        valid_in = 1;
        #2 reset = 0;
        #1;
        model_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_pxl_en", 32'(pxl_en), 32'd0);
        check_out();
        #2 reset = 1;
        valid_in = 0;
        w0 = win_seen; d0 = done_seen;
        idle_cycles(LAT + 3);
        chk("post_rst_quiet", 32'(win_seen - w0 + done_seen - d0), 32'd0);
        cyc(0, 1);
        for (int i = 0; i < DD; i++) cyc(1, 0);
        idle_cycles(LAT + 3);
        chk("frameP_windows", 32'(win_seen - w0), 32'(NWIN));
        chk("frameP_done", 32'(done_seen - d0), 32'd1);

        // Full D=220 frame on the second instance.
        start_b = 1;
        @(posedge clk);
        #1;
        start_b = 0;
        valid_b = 1;
        nb = 0; nd = 0; lr = -1; lc = -1; prev_busy = 1;
        for (int i = 0; i < DB * DB + LAT + 8; i++) begin
            @(posedge clk);
            #1;
            if (win_b === 1'b1) begin
                nb++;
                lr = int'(row_b);
                lc = int'(col_b);
            end
            if (done_b === 1'b1) begin
                nd++;
                chk("b_busy_at_done", 32'(busy_b), 32'd0);
                chk("b_busy_before_done", 32'(prev_busy), 32'd1);
            end
            prev_busy = busy_b;
        end
        valid_b = 0;
        chk("b_windows", 32'(nb), 32'(((DB - 3) / 2 + 1) * ((DB - 3) / 2 + 1)));
        chk("b_last_row", 32'(lr), 32'((DB - 3) / 2));
        chk("b_last_col", 32'(lc), 32'((DB - 3) / 2));
        chk("b_done_count", 32'(nd), 32'd1);
        chk("b_idle_busy", 32'(busy_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_s2_sched.md
CONV_S2_SCHED -- requirements
Module: conv_s2_sched

Interface
REQ-001 Parameter D, default 220, frame width and height in pixels (D >= 3).
REQ-002 Parameter DATA_WIDTH, default 32, kernel coefficient width.
REQ-003 Parameter LAT, default 3, datapath latency in cycles from the accepted completing pixel to the valid window sum (LAT >= 1).
REQ-004 Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle frame start request
- valid_in  in  1  upstream pixel valid
- in_ready  out  1  scheduler can accept a pixel
- pxl_en  out  1  pixel enable to the datapath, equal to valid_in & in_ready
- k_wr  in  1  kernel coefficient write strobe
- k_addr  in  4  coefficient index, 0..8, row-major
- k_data  in  DATA_WIDTH  coefficient value
- kernel_flat  out  9*DATA_WIDTH  coefficients; index n at bits [n*DATA_WIDTH +: DATA_WIDTH]
- win_valid  out  1  datapath output is a valid stride-2 window
- out_row  out  clog2(D)  output-map row of the current win_valid
- out_col  out  clog2(D)  output-map column of the current win_valid
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse at the end of a frame
- k_err  out  1  one-cycle pulse on a rejected kernel write

Function
REQ-005 FSM states are IDLE, RUN, DRAIN and DONE.
REQ-006 Transitions:
- IDLE->RUN on start.
- RUN->DRAIN in the cycle after the (D*D)-th pixel is accepted.
- DRAIN->DONE after LAT cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-007 start is ignored outside IDLE.
REQ-008 in_ready is high only in RUN; pxl_en is high only when valid_in & in_ready.
REQ-009 Column counter col (0..D-1) increments on each accepted pixel and wraps to 0 after D-1; row counter row increments on wrap; both clear on entry to RUN.
REQ-010 An accepted pixel at (row, col) completes a window when row >= 2, col >= 2, row is even and col is even.
REQ-011 A completing pixel raises win_valid exactly LAT cycles later, via a LAT-deep shift register that carries out_row = (row-2)/2 and out_col = (col-2)/2.
REQ-012 The shift register advances every cycle, independent of stalls, so LAT is measured in clock cycles.
REQ-013 Each frame produces exactly ((D-3)/2+1)^2 win_valid pulses, with integer division.
REQ-014 out_row and out_col are 0 whenever win_valid is low.
REQ-015 frame_done is high only in DONE; busy is high in RUN and DRAIN.
REQ-016 A kernel write with k_wr in IDLE and k_addr <= 8 updates coefficient k_addr at the next edge.
REQ-017 A kernel write with k_wr in any other state, or with k_addr > 8, is dropped and pulses k_err for one cycle.
REQ-018 A simultaneous k_wr and start in IDLE performs the write and also starts the frame.
REQ-019 Gaps in valid_in during RUN freeze row and col; no pixel is lost or duplicated.

Reset
REQ-020 Asserting reset (low) asynchronously forces the following, including mid-frame:
- state IDLE;
- row, col and the shift register cleared;
- kernel_flat all zero;
- all outputs low or zero.
REQ-021 After reset release, no win_valid or frame_done appears until a new start.

Structure
REQ-022 A shared package holds the FSM state encoding, the value 9 as the kernel-size constant, and a clog2 function.
REQ-023 The LAT-deep valid/coordinate delay line is the single sub-module, conv_s2_delay, parameterised by LAT and payload width.

Verification
REQ-024 D=6, LAT=3: start, then 36 back-to-back pixels -> win_valid exactly 4 times, 3 cycles after accepting pixels 14, 16, 26 and 28 (0-based), with (out_row, out_col) = (0,0), (0,1), (1,0), (1,1); frame_done 1 cycle after DRAIN.
REQ-025 D=6, valid_in toggling 1/0 every cycle -> the same 4 windows and coordinates; in_ready stays high for the whole RUN.
REQ-026 Load coefficients 1..9 in IDLE -> kernel_flat slices equal 1..9; a write with k_addr=9 -> k_err pulse and no change; a write during RUN -> k_err pulse and no change.
REQ-027 Reset driven low after pixel 20 of a D=6 frame -> all outputs zero immediately and state IDLE; a new start and 36 pixels -> the full 4-window sequence.
REQ-028 D=220, LAT=3, full frame -> 11881 win_valid pulses; last one at (108,108); busy falls in the same cycle frame_done rises.
REQ-029 start asserted in RUN and in DRAIN -> no effect: counters are not disturbed and exactly one frame_done pulse is produced.
